genome_search_axil_regs: RTL and testbench



---
 rtl/genome_search_axil_regs.sv | 186 ++++++++++++++++++
 tb/tb_genome_search_axil_regs.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/genome_search_axil_regs.sv
// AXI4-Lite register file for the genome off-target searcher: control/status,
// latched match count and general configuration registers for the search core.
module genome_search_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int NUM_REGS           = 16
) (
    input  logic                                     ACLK,
    input  logic                                     ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
    input  logic [2:0]                               S_AXI_AWPROT,
    input  logic                                     S_AXI_AWVALID,
    output logic                                     S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
    input  logic                                     S_AXI_WVALID,
    output logic                                     S_AXI_WREADY,
    output logic [1:0]                               S_AXI_BRESP,
    output logic                                     S_AXI_BVALID,
    input  logic                                     S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
    input  logic [2:0]                               S_AXI_ARPROT,
    input  logic                                     S_AXI_ARVALID,
    output logic                                     S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
    output logic [1:0]                               S_AXI_RRESP,
    output logic                                     S_AXI_RVALID,
    input  logic                                     S_AXI_RREADY,
    output logic                                     core_start,
    input  logic                                     core_busy,
    input  logic                                     core_done,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]            core_match_count,
    output logic [(NUM_REGS-3)*C_S_AXI_DATA_WIDTH-1:0] cfg_regs,
    output logic                                     irq
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int NB       = DW / 8;
    localparam int ADDR_LSB = $clog2(NB);
    localparam int IDX_W    = AW - ADDR_LSB;
    localparam logic [31:0] NUM_REGS_U  = 32'(NUM_REGS);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    logic             ready_q;
    logic             aw_held;
    logic             w_held;
    logic [IDX_W-1:0] aw_idx_q;
    logic [DW-1:0]    w_data_q;
    logic [NB-1:0]    w_strb_q;
    logic             irq_en_q;
    logic             done_q;
    logic             start_err_q;
    logic [DW-1:0]    match_q;

    logic             aw_hs;
    logic             w_hs;
    logic             ar_hs;
    logic             wr_fire;
    logic             wr_in_range;
    logic             rd_in_range;
    logic [IDX_W-1:0] ar_idx;
    logic [DW-1:0]    rd_data;
    logic             unused_ok;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return 32'(idx) < NUM_REGS_U;
    endfunction

    assign S_AXI_AWREADY = ready_q & ~aw_held & ~S_AXI_BVALID;
    assign S_AXI_WREADY  = ready_q & ~w_held & ~S_AXI_BVALID;
    assign S_AXI_ARREADY = ready_q & ~S_AXI_RVALID;

    assign aw_hs       = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs        = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs       = S_AXI_ARVALID & S_AXI_ARREADY;
    assign wr_fire     = aw_held & w_held;
    assign wr_in_range = in_range(aw_idx_q);
    assign ar_idx      = S_AXI_ARADDR[AW-1:ADDR_LSB];
    assign rd_in_range = in_range(ar_idx);

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    always_comb begin
        rd_data = '0;
        if (rd_in_range) begin
            if (ar_idx == IDX_W'(0)) begin
                rd_data[1] = irq_en_q;
            end else if (ar_idx == IDX_W'(1)) begin
                rd_data[0] = core_busy;
                rd_data[1] = done_q;
                rd_data[2] = start_err_q;
            end else if (ar_idx == IDX_W'(2)) begin
                rd_data = match_q;
            end else begin
                for (int r = 3; r < NUM_REGS; r++) begin
                    if (ar_idx == IDX_W'(r)) rd_data = cfg_regs[(r-3)*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ready_q      <= 1'b0;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_idx_q     <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            start_err_q  <= 1'b0;
            match_q      <= '0;
            cfg_regs     <= '0;
            core_start   <= 1'b0;
            irq          <= 1'b0;
        end else begin
            ready_q    <= 1'b1;
            core_start <= 1'b0;
            irq        <= irq_en_q & done_q;
            if (aw_hs) begin
                aw_held  <= 1'b1;
                aw_idx_q <= S_AXI_AWADDR[AW-1:ADDR_LSB];
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
            if (wr_fire) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                if (wr_in_range) begin
                    if (aw_idx_q == IDX_W'(0) && w_strb_q[0]) begin
                        irq_en_q <= w_data_q[1];
                        if (w_data_q[0]) begin
                            if (core_busy) start_err_q <= 1'b1;
                            else           core_start  <= 1'b1;
                        end
                    end
                    if (aw_idx_q == IDX_W'(1) && w_strb_q[0]) begin
                        if (w_data_q[1]) done_q      <= 1'b0;
                        if (w_data_q[2]) start_err_q <= 1'b0;
                    end
                    for (int r = 3; r < NUM_REGS; r++) begin
                        if (aw_idx_q == IDX_W'(r)) begin
                            for (int b = 0; b < NB; b++) begin
                                if (w_strb_q[b])
                                    cfg_regs[(r-3)*DW + b*8 +: 8] <= w_data_q[b*8 +: 8];
                            end
                        end
                    end
                end
            end
            // Placed after the W1C so a coincident completion keeps DONE set.
            if (core_done) begin
                done_q  <= 1'b1;
                match_q <= core_match_count;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= RESP_OKAY;
        end else begin
            if (S_AXI_RVALID && S_AXI_RREADY) S_AXI_RVALID <= 1'b0;
            if (ar_hs) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_data;
                S_AXI_RRESP  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

endmodule

// File: tb/tb_genome_search_axil_regs.sv
// Directed bench for genome_search_axil_regs with a register-level model of the
// programmer-visible state and a per-cycle compare of cfg_regs, irq and core_start.
module tb_genome_search_axil_regs;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NR = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [AW-1:0]        awaddr = '0;
    logic [2:0]           awprot = '0;
    logic                 awvalid = 1'b0;
    logic                 awready;
    logic [DW-1:0]        wdata = '0;
    logic [DW/8-1:0]      wstrb = '0;
    logic                 wvalid = 1'b0;
    logic                 wready;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready = 1'b0;
    logic [AW-1:0]        araddr = '0;
    logic [2:0]           arprot = '0;
    logic                 arvalid = 1'b0;
    logic                 arready;
    logic [DW-1:0]        rdata;
    logic [1:0]           rresp;
    logic                 rvalid;
    logic                 rready = 1'b0;
    logic                 core_start;
    logic                 core_busy = 1'b0;
    logic                 core_done = 1'b0;
    logic [DW-1:0]        core_match_count = '0;
    logic [(NR-3)*DW-1:0] cfg_regs;
    logic                 irq;

    genome_search_axil_regs #(
        .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .NUM_REGS(NR)
    ) dut (
        .ACLK(clk), .ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready),
        .core_start(core_start), .core_busy(core_busy), .core_done(core_done),
        .core_match_count(core_match_count), .cfg_regs(cfg_regs), .irq(irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model of the register map as software sees it.
    logic [31:0] m_cfg [NR];
    logic        m_irq_en, m_done, m_err;
    logic [31:0] m_match;
    int          m_starts = 0;
    int          seen_starts = 0;
    bit          sync = 1'b0;
    bit          start_prev = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [447:0] act, input logic [447:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input int idx);
        if (idx == 0) return {30'd0, m_irq_en, 1'b0};
        if (idx == 1) return {29'd0, m_err, m_done, core_busy};
        if (idx == 2) return m_match;
        if (idx < NR) return m_cfg[idx];
        return 32'd0;
    endfunction

    function automatic logic [(NR-3)*DW-1:0] model_cfg_vec();
        logic [(NR-3)*DW-1:0] v;
        v = '0;
        for (int r = 3; r < NR; r++) v[(r-3)*DW +: DW] = m_cfg[r];
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) m_cfg[r] = 32'd0;
        m_irq_en = 1'b0; m_done = 1'b0; m_err = 1'b0; m_match = 32'd0;
    endtask

    task automatic model_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
        if (idx >= NR) return;
        if (idx == 0 && strb[0]) begin
            m_irq_en = data[1];
            if (data[0]) begin
                if (core_busy) m_err = 1'b1;
                else           m_starts++;
            end
        end else if (idx == 1 && strb[0]) begin
            if (data[1]) m_done = 1'b0;
            if (data[2]) m_err  = 1'b0;
        end else if (idx >= 3) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) m_cfg[idx][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    always @(negedge clk) begin
        chk("start_width", core_start & start_prev, 1'b0);
        if (core_start) seen_starts++;
        start_prev = core_start;
        if (sync) begin
            chk("cfg_regs", cfg_regs, model_cfg_vec());
            chk("irq", irq, m_irq_en & m_done);
        end
    end

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_dly, input bit done_hit, input string tag);
        int  k, j, idx, aw_c, w_c, hs_c;
        bit  aw_done, w_done, aw_go, w_go, exp_pulse;
        idx = int'(addr) >> 2;
        exp_pulse = (idx == 0) && strb[0] && data[0] && !core_busy;
        sync = 1'b0;
        @(negedge clk);
        k = 0; aw_done = 0; w_done = 0; aw_c = 0; w_c = 0;
        while (!(aw_done && w_done) && k < 40) begin
            if (!aw_done && k >= aw_dly) begin awaddr = addr; awvalid = 1'b1; end
            if (!w_done && k >= w_dly) begin wdata = data; wstrb = strb; wvalid = 1'b1; end
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            @(negedge clk);
            k++;
            if (aw_go) begin awvalid = 1'b0; aw_done = 1; aw_c = cyc; end
            if (w_go)  begin wvalid  = 1'b0; w_done  = 1; w_c  = cyc; end
        end
        chk({tag, "_handshake"}, {aw_done, w_done}, 2'b11);
        awvalid = 1'b0; wvalid = 1'b0;
        hs_c = (aw_c > w_c) ? aw_c : w_c;
        if (done_hit) core_done = 1'b1;
        j = 0;
        do begin
            @(negedge clk);
            core_done = 1'b0;
            j++;
        end while (!bvalid && j < 20);
        chk({tag, "_bvalid"}, bvalid, 1'b1);
        chk({tag, "_blat"}, cyc - hs_c, 1);
        chk({tag, "_core_start"}, core_start, exp_pulse);
        chk({tag, "_bresp"}, bresp, (idx >= NR) ? 2'b10 : 2'b00);
        for (int i = 0; i < b_dly; i++) begin
            chk({tag, "_bhold"}, bvalid, 1'b1);
            chk({tag, "_awready_blocked"}, awready, 1'b0);
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk({tag, "_bclear"}, bvalid, 1'b0);
        model_write(idx, data, strb);
        if (done_hit) begin m_done = 1'b1; m_match = core_match_count; end
        @(negedge clk);
        sync = 1'b1;
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat);
        int k, ar_c;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        k = 0;
        while (!arready && k < 20) begin @(negedge clk); k++; end
        ar_c = cyc;
        @(negedge clk);
        arvalid = 1'b0;
        k = 0;
        while (!rvalid && k < 20) begin @(negedge clk); k++; end
        lat  = cyc - ar_c;
        data = rdata;
        resp = rresp;
        if (!rvalid) lat = -1;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic read_chk(input logic [7:0] addr, input string tag, output logic [31:0] data);
        logic [1:0] resp;
        int lat, idx;
        idx = int'(addr) >> 2;
        axi_read(addr, data, resp, lat);
        chk({tag, "_rdata"}, data, model_read(idx));
        chk({tag, "_rresp"}, resp, (idx >= NR) ? 2'b10 : 2'b00);
        chk({tag, "_rlat"}, lat, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_awready", awready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_cfg", cfg_regs, '0);
        chk("rst_irq", irq, 1'b0);
        rst_n = 1'b1;
        chk("ready_before_edge", awready, 1'b0);
        @(negedge clk);
        chk("ready_after_edge", {awready, wready, arready}, 3'b111);
        sync = 1'b1;

        for (int r = 3; r < NR; r++)
            axi_write(8'(r*4), 32'(r-2), 4'hF, 0, 0, 0, 1'b0, "cfg_wr");
        for (int r = 3; r < NR; r++)
            read_chk(8'(r*4), "cfg_rd", d);
        chk("cfg_lit_r15", d, 32'h0000000D);

        axi_write(8'h10, 32'hAABBCCDD, 4'hF, 0, 0, 0, 1'b0, "r4_full");
        axi_write(8'h10, 32'h11223344, 4'b0010, 0, 0, 0, 1'b0, "r4_strb");
        read_chk(8'h10, "r4", d);
        chk("r4_lit", d, 32'hAABB33DD);

        axi_write(8'h14, 32'h00000055, 4'hF, 0, 3, 0, 1'b0, "aw_first");
        axi_write(8'h18, 32'h00000066, 4'hF, 3, 0, 5, 1'b0, "w_first");
        read_chk(8'h14, "aw_first", d);
        read_chk(8'h18, "w_first", d);
        chk("w_first_lit", d, 32'h00000066);

        core_busy = 1'b0;
        axi_write(8'h00, 32'h3, 4'hF, 0, 0, 0, 1'b0, "start_idle");
        chk("start_count1", seen_starts, 1);
        core_busy = 1'b1;
        axi_write(8'h00, 32'h3, 4'hF, 0, 0, 0, 1'b0, "start_busy");
        chk("start_count2", seen_starts, 1);
        read_chk(8'h04, "status_err", d);
        chk("status_lit5", d, 32'h5);
        read_chk(8'h00, "control", d);

        core_busy = 1'b0;
        sync = 1'b0;
        @(negedge clk);
        core_match_count = 32'h2A; core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0; m_done = 1'b1; m_match = 32'h2A;
        @(negedge clk);
        sync = 1'b1;
        read_chk(8'h08, "match", d);
        chk("match_lit", d, 32'h2A);
        read_chk(8'h04, "status_done", d);
        chk("status_done_bit", d[1], 1'b1);
        chk("irq_lit1", irq, 1'b1);
        axi_write(8'h04, 32'h2, 4'hF, 0, 0, 0, 1'b1, "w1c_vs_done");
        read_chk(8'h04, "status_setwins", d);
        chk("status_setwins_lit", d, 32'h6);
        axi_write(8'h04, 32'h6, 4'hF, 0, 0, 0, 1'b0, "w1c_all");
        read_chk(8'h04, "status_clear", d);
        chk("irq_lit0", irq, 1'b0);

        axi_write(8'h50, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 1'b0, "oor_wr");
        read_chk(8'h50, "oor_rd", d);
        read_chk(8'h10, "r4_after_oor", d);
        chk("r4_after_oor_lit", d, 32'hAABB33DD);

        sync = 1'b0;
        @(negedge clk);
        awaddr = 8'h0C; awvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", {awready, wready, arready}, 3'b000);
        chk("mid_rst_b", {bvalid, bresp}, 3'b000);
        chk("mid_rst_r", {rvalid, rresp, rdata}, '0);
        chk("mid_rst_core", {core_start, irq}, 2'b00);
        chk("mid_rst_cfg", cfg_regs, '0);
        model_reset();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready_back", awready, 1'b1);
        sync = 1'b1;
        read_chk(8'h0C, "r3_after_rst", d);
        read_chk(8'h08, "match_after_rst", d);
        read_chk(8'h04, "status_after_rst", d);

        chk("start_total", seen_starts, m_starts);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
